// File: rtl/macro_seq_layer3_if.sv
// Handshake and macro-bus bundle for the layer-3 CIM sequencer.
// slave: the sequencer; master: the window source, macro bank and result sink.
interface macro_seq_layer3_if #(
    parameter int FM_DEPTH  = 64,
    parameter int CORE_SIZE = 9,
    parameter int MACRO_NUM = 4,
    parameter int ACC_W     = 6
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [FM_DEPTH-1:0][CORE_SIZE-1:0]     in_data;
    logic [FM_DEPTH-1:0][CORE_SIZE-1:0]     macro_din;
    logic                                   macro_en;
    logic                                   macro_adc;
    logic [1:0]                             macro_ps;
    logic [MACRO_NUM-1:0][63:0][3:0]        macro_dout;
    logic [MACRO_NUM-1:0][63:0][ACC_W-1:0]  psum_out;
    logic                                   out_valid;
    logic                                   out_ready;

    modport slave (
        input  in_valid, in_data, macro_dout, out_ready,
        output in_ready, macro_din, macro_en, macro_adc,
        output macro_ps, psum_out, out_valid
    );

    modport master (
        output in_valid, in_data, macro_dout, out_ready,
        input  in_ready, macro_din, macro_en, macro_adc,
        input  macro_ps, psum_out, out_valid
    );
endinterface

// File: rtl/macro_seq_layer3.sv
// Layer-3 CIM macro bank sequencer: latches a window, walks the
// compute/convert/capture phases and accumulates signed column psums.
module macro_seq_layer3 #(
    parameter int FM_DEPTH   = 64,
    parameter int CORE_SIZE  = 9,
    parameter int MACRO_NUM  = 4,
    parameter int PS_NUM     = 4,
    parameter int CMP_CYCLES = 2,
    parameter int ADC_CYCLES = 3,
    parameter int ACC_W      = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    output logic              busy,
    macro_seq_layer3_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COMP, CONV, CAPT, DONE} state_t;

    localparam int MAXC  = (CMP_CYCLES > ADC_CYCLES) ? CMP_CYCLES : ADC_CYCLES;
    localparam int CNT_W = $clog2(MAXC) + 1;

    state_t                                state;
    state_t                                state_nx;
    logic [CNT_W-1:0]                      cnt;
    logic [CNT_W-1:0]                      cnt_nx;
    logic [1:0]                            phase;
    logic [1:0]                            phase_nx;
    logic                                  last;
    logic [FM_DEPTH-1:0][CORE_SIZE-1:0]    din_q;
    logic [MACRO_NUM-1:0][63:0][ACC_W-1:0] acc_q;

    assign last = (phase == 2'(PS_NUM - 1));

    // State, phase and dwell counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            phase <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            phase <= phase_nx;
        end
    end

    // Next-state logic; clr wins over every handshake.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        phase_nx = phase;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            phase_nx = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_nx = COMP;
                        cnt_nx   = '0;
                        phase_nx = '0;
                    end
                end
                COMP: begin
                    if (cnt == CNT_W'(CMP_CYCLES - 1)) begin
                        state_nx = CONV;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(ADC_CYCLES - 1)) begin
                        state_nx = CAPT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                CAPT: begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = COMP;
                        phase_nx = phase + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nx = IDLE;
                        phase_nx = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Window latch on accept and per-column accumulation on capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_q <= '0;
            acc_q <= '0;
        end else if (!clr) begin
            if (state == IDLE && bus.in_valid) begin
                din_q <= bus.in_data;
            end
            if (state == CAPT) begin
                for (int m = 0; m < MACRO_NUM; m++) begin
                    for (int c = 0; c < 64; c++) begin
                        acc_q[m][c] <= ((phase == 2'd0) ? '0 : acc_q[m][c])
                            + {{(ACC_W-4){bus.macro_dout[m][c][3]}},
                               bus.macro_dout[m][c]};
                    end
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.macro_en  = (state == COMP) || (state == CONV) || (state == CAPT);
    assign bus.macro_adc = (state == CONV);
    assign bus.macro_ps  = phase;
    assign bus.out_valid = (state == DONE);
    assign bus.macro_din = din_q;
    assign bus.psum_out  = acc_q;
endmodule
